// File: rtl/demux_pkg.sv
// Shared lane/select definitions for the 1x4 demux and 4x1 mux ends of the path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Lane index following g in ascending order; wraps 3 -> 0 through the 2-bit width.
  function automatic sel_t next_lane(input sel_t g);
    return g + sel_t'(1);
  endfunction

endpackage

// File: rtl/rr_mux_4x1_arbiter.sv
// Round-robin request picker: first asserted request at or after ptr, ascending mod 4.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own load condition.
module rr_arbiter_4
  import demux_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  sel_t                 ptr,
  output logic                 gnt_valid,
  output sel_t                 gnt
);

  // Walk the lanes starting at ptr; the first requester found wins.
  always_comb begin
    sel_t idx;
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr + sel_t'(k);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt       = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux_4x1.sv
// Merges four valid/ready lanes onto one stream, round-robin, reporting the source lane.
// Latency: 1 cycle from lane handshake to beat on out_*; 1 beat/cycle sustained.
// Backpressure: a held beat with out_ready=0 stalls everything; all in_ready drop.
module rr_mux_4x1
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES-1:0]       in_valid,
  input  logic [NUM_LANES*WIDTH-1:0] in_data,
  output logic [NUM_LANES-1:0]       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output sel_t                       out_sel,
  input  logic                       out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  sel_t             out_sel_q,   out_sel_d;
  sel_t             ptr_q,       ptr_d;

  logic             load;
  logic             gnt_valid;
  sel_t             gnt;
  logic [WIDTH-1:0] gnt_data;

  // Output register is free when empty or when its beat leaves this cycle.
  assign load = !out_valid_q || out_ready;

  rr_arbiter_4 u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  // Pick the granted lane's data out of the flattened input bus.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (gnt == sel_t'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Only the granted lane sees ready, and only when the beat can actually be taken.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && gnt_valid) in_ready[gnt] = 1'b1;
  end

  // Next state: load a granted beat, go empty on no grant, hold everything on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = gnt_data;
        out_sel_d   = gnt;
        ptr_d       = next_lane(gnt);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output stage and round-robin pointer; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Directed bench for rr_mux_4x1: reset, single lane, skip/wrap, mid-stream reset,
// rotation, stall.
module tb_rr_mux_4x1;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  logic [WIDTH-1:0] lane_dat [4];

  int checks = 0;
  int errors = 0;

  assign in_data = {lane_dat[3], lane_dat[2], lane_dat[1], lane_dat[0]};

  rr_mux_4x1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
    check({tag, "_sel"},   {30'd0, out_sel},   {30'd0, s});
  endtask

  initial begin
    logic [1:0] exp_sel;

    // Reset with all lanes valid
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) lane_dat[i] = 8'h10 + 8'(i);
    #1;
    check("rst_rdy0", {28'd0, in_ready}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check_out("rst", 1'b0, 8'h00, 2'b00);
      check("rst_rdy", {28'd0, in_ready}, 32'h0);
    end

    // Single lane 2
    rst_n       = 1'b1;
    in_valid    = 4'b0100;
    lane_dat[2] = 8'hA5;
    #1;
    check("single_rdy", {28'd0, in_ready}, 32'b0100);
    tick();
    check_out("single_beat", 1'b1, 8'hA5, 2'b10);
    in_valid = 4'b0000;
    #1;
    check("single_rdy_idle", {28'd0, in_ready}, 32'h0);
    tick();
    check("single_drain", {31'd0, out_valid}, 32'd0);

    // Skip + wrap: ptr=3 now, lanes 1 and 3 valid
    in_valid    = 4'b1010;
    lane_dat[1] = 8'h21;
    lane_dat[3] = 8'h23;
    #1;
    check("wrap_rdy3", {28'd0, in_ready}, 32'b1000);
    tick();
    check_out("wrap_beat3", 1'b1, 8'h23, 2'b11);
    check("wrap_rdy1", {28'd0, in_ready}, 32'b0010);
    tick();
    check_out("wrap_beat1", 1'b1, 8'h21, 2'b01);

    // Mid-stream reset: ptr=2, load a beat from lane 2, then reset
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) lane_dat[i] = 8'h10 + 8'(i);
    tick();
    check_out("pre_rst", 1'b1, 8'h12, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", {28'd0, in_ready}, 32'h0);
    tick();
    check_out("mid_rst", 1'b0, 8'h00, 2'b00);
    rst_n = 1'b1;

    // Rotation from lane 0 after reset, one beat per cycle
    for (int k = 0; k < 5; k++) begin
      exp_sel = 2'(k % 4);
      #1;
      check("rot_rdy", {28'd0, in_ready}, 32'd1 << exp_sel);
      tick();
      check_out("rot", 1'b1, 8'h10 + 8'(exp_sel), exp_sel);
    end

    // Stall: load 3C from lane 1, hold it 5 cycles, then release
    lane_dat[1] = 8'h3C;
    tick();
    check_out("stall_load", 1'b1, 8'h3C, 2'b01);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_rdy", {28'd0, in_ready}, 32'h0);
      tick();
      check_out("stall_hold", 1'b1, 8'h3C, 2'b01);
    end
    out_ready = 1'b1;
    #1;
    check("release_rdy", {28'd0, in_ready}, 32'b0100);
    tick();
    check_out("release", 1'b1, 8'h12, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
